// File: rtl/dmem_apb_slave_pkg.sv
// Shared types for the DMEM APB completer: FSM state encoding and word size.
package typedefs;

  localparam int unsigned DMEM_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } apb_slv_state_e;

endpackage

// File: rtl/apb_if.sv
// APB bundle between the load-store unit (master) and the DMEM completer (slave).
interface apb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DAT_W  = 32
);

  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [ADDR_W-1:0]    paddr;
  logic [DAT_W-1:0]     pwdata;
  logic [DAT_W/8-1:0]   pstrb;
  logic [DAT_W-1:0]     prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/dmem_apb_slave_sram_1rw_be.sv
// Single-port DMEM word array: synchronous read, four byte-write enables,
// contents not reset. A read and write to the same index on one edge returns
// the word as it was before the write.
module sram_1rw_be #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           re_i,
  input  logic [3:0]                     we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Byte-masked write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_apb_slave.sv
// DMEM APB completer: decodes the address window, latches the transfer at
// SETUP, optionally inserts wait states, and answers with registered
// pready/pslverr/prdata. Optional feature macro: DMEM_WAIT_STATES_EN (wait
// counter, WAIT state and APB protocol assertions).
module dmem_apb_slave
  import typedefs::*;
#(
  parameter int unsigned        ADDR_W      = 32,
  parameter int unsigned        DAT_W       = 32,
  parameter int unsigned        DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned        WAIT_CYCLES = 1
) (
  input  logic  clk,
  input  logic  rst,
  apb_if.slave  dmem_apb
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned OFF_W = IDX_W + $clog2(DMEM_WORD_BYTES);

  if (DAT_W != 32 || WAIT_CYCLES > 15 || DEPTH_WORDS < 2 ||
      (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0 ||
      BASE_ADDR[OFF_W-1:0] != '0) begin : g_param_check
    $error("dmem_apb_slave: unsupported parameter set");
  end

  apb_slv_state_e     state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               write_q, write_d;
  logic [DAT_W-1:0]   wdata_q, wdata_d;
  logic [3:0]         strb_q, strb_d;
  logic               err_q, err_d;
  logic               pready_q;
  logic               pslverr_q;
  logic               rd_ok_q;

  logic               setup;
  logic               addr_err;
  logic               sram_re;
  logic [3:0]         sram_we;
  logic [IDX_W-1:0]   sram_idx;
  logic [31:0]        sram_rdata;

`ifdef DMEM_WAIT_STATES_EN
  logic [3:0]         wcnt_q, wcnt_d;
`endif

  assign setup = dmem_apb.psel && !dmem_apb.penable;

  // BASE_ADDR is aligned to the window size, so the window test reduces to
  // comparing the bits above the offset, and (paddr-BASE_ADDR)>>2 is simply
  // the in-window word-index bits of paddr.
  assign addr_err = (dmem_apb.paddr[1:0] != 2'b00) ||
                    (dmem_apb.paddr[ADDR_W-1:OFF_W] != BASE_ADDR[ADDR_W-1:OFF_W]);

  // Next-state, transfer capture and SRAM port control.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    err_d    = err_q;
    sram_re  = 1'b0;
    sram_we  = '0;
    sram_idx = idx_q;
`ifdef DMEM_WAIT_STATES_EN
    wcnt_d   = wcnt_q;
`endif
    case (state_q)
      IDLE: begin
        sram_idx = dmem_apb.paddr[OFF_W-1:2];
        if (setup) begin
          idx_d   = dmem_apb.paddr[OFF_W-1:2];
          write_d = dmem_apb.pwrite;
          wdata_d = dmem_apb.pwdata;
          strb_d  = dmem_apb.pstrb;
          err_d   = addr_err;
          sram_re = !dmem_apb.pwrite && !addr_err;
`ifdef DMEM_WAIT_STATES_EN
          wcnt_d  = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES != 0) ? WAIT : ACCESS;
`else
          state_d = ACCESS;
`endif
        end
      end
`ifdef DMEM_WAIT_STATES_EN
      WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (!dmem_apb.psel) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q <= 4'd1) begin
          state_d = ACCESS;
        end
      end
`endif
      ACCESS: begin
        if (dmem_apb.psel && write_q && !err_q) begin
          sram_we = strb_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      sram_we = '0;
    end
  end

  // State, latched transfer and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      rd_ok_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
      pready_q  <= (state_d == ACCESS);
      pslverr_q <= (state_d == ACCESS) && err_d;
      rd_ok_q   <= (state_d == ACCESS) && !write_d && !err_d;
    end
  end

`ifdef DMEM_WAIT_STATES_EN
  // Wait-state down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

  a_psel_held: assert property (@(posedge clk) disable iff (rst)
    (state_q != IDLE) |-> dmem_apb.psel);

  a_ctrl_stable: assert property (@(posedge clk) disable iff (rst)
    (dmem_apb.psel && dmem_apb.penable && $past(dmem_apb.psel)) |->
      ($stable(dmem_apb.paddr) && $stable(dmem_apb.pwrite) && $stable(dmem_apb.pwdata)));
`endif

  sram_1rw_be #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .clk     (clk),
    .re_i    (sram_re),
    .we_i    (sram_we),
    .idx_i   (sram_idx),
    .wdata_i (wdata_q),
    .rdata_o (sram_rdata)
  );

  // The SRAM output register holds the word from the SETUP edge; it is only
  // exposed during the ACCESS cycle of an error-free read.
  assign dmem_apb.prdata  = rd_ok_q ? sram_rdata : '0;
  assign dmem_apb.pready  = pready_q;
  assign dmem_apb.pslverr = pslverr_q;

endmodule

// File: tb/tb_dmem_apb_slave.sv
// Self-checking bench for dmem_apb_slave: directed vector table, multi-cycle
// corner sequences and randomized back-to-back traffic against a word-array
// model. Honours DMEM_WAIT_STATES_EN (two wait states when defined).
module tb_dmem_apb_slave;
  import typedefs::*;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0001_0000;
`ifdef DMEM_WAIT_STATES_EN
  localparam int unsigned NW = 2;
`else
  localparam int unsigned NW = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  apb_if #(.ADDR_W(32), .DAT_W(32)) bus ();

  dmem_apb_slave #(
    .ADDR_W      (32),
    .DAT_W       (32),
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dmem_apb (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem_m [DEPTH];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", nm, act, exp);
    end
  endtask

  function automatic bit m_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (longint'(a) < longint'(BASE)) ||
           (longint'(a) >= longint'(BASE) + longint'(DEPTH * 4));
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (!m_err(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mem_m[m_idx(a)][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  // Starts at posedge+1; leaves at posedge+1 of the cycle after the ACCESS
  // cycle with psel still asserted, so calls chain back-to-back.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic e,
                      output int unsigned cyc);
    bit done;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = a; bus.pwdata = d; bus.pstrb = s;
    cyc = 1; rd = '0; e = 1'b0; done = 1'b0;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    while (!done) begin
      cyc++;
      @(negedge clk);
      if (bus.pready) begin
        rd = bus.prdata; e = bus.pslverr; done = 1'b1;
        @(posedge clk); #1;
      end else if (cyc > 40) begin
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic mxfer(input string nm, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd, exp;
    logic e;
    int unsigned c;
    exp = 32'h0;
    if (!wr && !m_err(a)) exp = mem_m[m_idx(a)];
    xfer(wr, a, d, s, rd, e, c);
    check({nm, "_rdata"}, rd, exp);
    check({nm, "_err"}, 32'(e), 32'(m_err(a)));
    check({nm, "_cycles"}, c, 2 + NW);
    if (wr) m_write(a, d, s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic e;
    int unsigned c;
    logic [31:0] a;

    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;

    tbl[0]  = '{1'b1, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF,    32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b0, 32'h0001_0010, 32'h0000_0000, 4'h0,    32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h0001_0014, 32'h1122_3344, 4'hF,    32'h0000_0000, 1'b0};
    tbl[3]  = '{1'b1, 32'h0001_0014, 32'hAABB_CCDD, 4'b0100, 32'h0000_0000, 1'b0};
    tbl[4]  = '{1'b0, 32'h0001_0014, 32'h0000_0000, 4'h3,    32'h11BB_3344, 1'b0};
    tbl[5]  = '{1'b1, 32'h0001_0014, 32'hAABB_CCDD, 4'b0011, 32'h0000_0000, 1'b0};
    tbl[6]  = '{1'b0, 32'h0001_0014, 32'h0000_0000, 4'h0,    32'h11BB_CCDD, 1'b0};
    tbl[7]  = '{1'b1, 32'h0001_0018, 32'h5566_7788, 4'h0,    32'h0000_0000, 1'b0};
    tbl[8]  = '{1'b0, 32'h0001_0018, 32'h0000_0000, 4'h0,    32'hA500_0006, 1'b0};
    tbl[9]  = '{1'b0, 32'h0001_0002, 32'h0000_0000, 4'hF,    32'h0000_0000, 1'b1};
    tbl[10] = '{1'b1, 32'h0001_0100, 32'hFFFF_FFFF, 4'hF,    32'h0000_0000, 1'b1};
    tbl[11] = '{1'b0, 32'h0001_00FC, 32'h0000_0000, 4'h0,    32'hA500_003F, 1'b0};
    tbl[12] = '{1'b0, 32'h0000_FFFC, 32'h0000_0000, 4'h0,    32'h0000_0000, 1'b1};
    tbl[13] = '{1'b1, 32'h0001_00FC, 32'h1234_5678, 4'b1000, 32'h0000_0000, 1'b0};
    tbl[14] = '{1'b0, 32'h0001_00FC, 32'h0000_0000, 4'h0,    32'h1200_003F, 1'b0};
    tbl[15] = '{1'b1, 32'h0001_0022, 32'h0BAD_0BAD, 4'hF,    32'h0000_0000, 1'b1};

    // Reset held for three cycles: outputs quiet throughout.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_pready", 32'(bus.pready), 32'h0);
      check("rst_pslverr", 32'(bus.pslverr), 32'h0);
      check("rst_prdata", bus.prdata, 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Preload every word with a known pattern.
    for (int i = 0; i < int'(DEPTH); i++) begin
      xfer(1'b1, BASE + 32'(i * 4), 32'hA500_0000 | 32'(i), 4'hF, rd, e, c);
      check("preload_cycles", c, 2 + NW);
      mem_m[i] = 32'hA500_0000 | 32'(i);
    end

    // Directed vectors with hand-derived expectations.
    for (int i = 0; i < 16; i++) begin
      xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, rd, e, c);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
      check($sformatf("vec%0d_cycles", i), c, 2 + NW);
      if (tbl[i].wr) m_write(tbl[i].addr, tbl[i].wdata, tbl[i].strb);
    end

    // Error writes must have left every word untouched.
    for (int i = 0; i < int'(DEPTH); i++) begin
      mxfer("sweep1", 1'b0, BASE + 32'(i * 4), 32'h0, 4'h0);
    end

    // prdata drops back to zero the cycle after the read completes.
    mxfer("rd_then_idle", 1'b0, BASE + 32'h10, 32'h0, 4'h0);
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge clk);
    check("idle_prdata", bus.prdata, 32'h0);
    check("idle_pready", 32'(bus.pready), 32'h0);
    @(posedge clk); #1;

    // Reset during the post-SETUP cycle of a write discards it.
    mxfer("pre_rst_wr", 1'b1, BASE + 32'h20, 32'h0000_0005, 4'hF);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = BASE + 32'h20; bus.pwdata = 32'hCAFE_F00D; bus.pstrb = 4'hF;
    @(posedge clk); #1;
    bus.penable = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge clk);
    check("midrst_pready", 32'(bus.pready), 32'h0);
    check("midrst_state", 32'(dut.state_q), 32'(IDLE));
    @(posedge clk); #1;
    xfer(1'b0, BASE + 32'h20, 32'h0, 4'h0, rd, e, c);
    check("midrst_readback", rd, 32'h0000_0005);

`ifndef DMEM_WAIT_STATES_EN
    // psel dropped in the ACCESS cycle: the write must not commit.
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = BASE + 32'h24; bus.pwdata = 32'h0BAD_0BAD; bus.pstrb = 4'hF;
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, BASE + 32'h24, 32'h0, 4'h0, rd, e, c);
    check("abort_readback", rd, 32'hA500_0009);
`endif

    // Randomized back-to-back write/read pairs.
    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(0, 7) == 0) a = BASE + 32'($urandom_range(0, DEPTH * 4 + 15));
      else a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
      mxfer("rnd_wr", 1'b1, a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 0) a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
      mxfer("rnd_rd", 1'b0, a, $urandom, 4'($urandom_range(0, 15)));
    end

    for (int i = 0; i < int'(DEPTH); i++) begin
      mxfer("sweep2", 1'b0, BASE + 32'(i * 4), 32'h0, 4'h0);
    end

    bus.psel = 1'b0; bus.penable = 1'b0;
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_apb_slave.md
# dmem_apb_slave

APB completer that terminates the data-memory APB bus driven by the execute/memory/writeback stage's load-store unit. It holds the DMEM word array and services byte, half and word loads and stores through APB byte strobes. It inserts a configurable number of wait states, and it reports out-of-range or misaligned accesses on `pslverr`. It sits at the top level beside the core and connects through the `apb_if.slave` modport.

## Interface

Parameters:

- `ADDR_W`, default 32: APB address width.
- `DAT_W`, default 32: APB data width. Fixed at 32; other values are unsupported.
- `DEPTH_WORDS`, default 1024: number of 32-bit words. Must be a power of 2.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0. Must be aligned to `DEPTH_WORDS*4`.
- `WAIT_CYCLES`, default 1: wait states per access. Range 0..15. Only used when `DMEM_WAIT_STATES_EN` is defined.

Ports:

- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset.
- `dmem_apb`, `apb_if.slave`, bundle:
  - Inputs: `psel`, `penable`, `pwrite`, `paddr[31:0]`, `pwdata[31:0]`, `pstrb[3:0]`.
  - Outputs: `prdata[31:0]`, `pready`, `pslverr`.

## Operation

- The FSM state type is `apb_slv_state_e`, with states IDLE, ACCESS, WAIT.
- **IDLE**
  - If `psel && !penable` (SETUP phase), latch `paddr`, `pwrite`, `pwdata` and `pstrb`.
  - In the same cycle, evaluate the error condition and issue the SRAM read for the word index `(paddr-BASE_ADDR)>>2`.
  - Next state is WAIT if the wait count is greater than 0, otherwise ACCESS.
- **WAIT**
  - A down-counter is loaded with `WAIT_CYCLES` at SETUP. It decrements each cycle.
  - `pready` stays 0 while in WAIT.
  - When the counter reaches 1, go to ACCESS.
- **ACCESS**
  - Drive `pready`=1.
  - Drive `pslverr` from the latched error condition.
  - For reads, drive `prdata` from the SRAM read word. For writes, `prdata` is 0.
  - A write commits in this cycle only. For each i, byte lane i is written iff `pstrb[i]` is set and there is no error.
  - Next state is IDLE.
- **Error condition**: either of:
  - `paddr[1:0]` is not `2'b00`.
  - `paddr` lies outside `[BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4)`.
- **On error**: no write occurs. For reads, `prdata`=0.
- **Read and strobes**: a read ignores `pstrb` and always returns the full word. The requester performs sign/zero extension.
- **Zero strobes**: a write with `pstrb`=0 completes normally with no memory change.
- **Aborted transfer**: if `psel` drops while in WAIT or ACCESS, return to IDLE and commit no write. This is a protocol violation and is flagged in simulation by the `DMEM_WAIT_STATES_EN` assertion block.
- **Reset**: `rst` forces IDLE in the next cycle, from any state.
  - A pending write is discarded.
  - Memory contents are not cleared.

## Timing

- **Reset values**: `pready`=0, `pslverr`=0, `prdata`=0, state=IDLE, wait counter=0.
- **Zero-wait access**:
  - SETUP in cycle T, with the FSM in IDLE.
  - ACCESS in T+1, with `pready`=1.
  - Transfer completes at the end of T+1.
- **N-wait access**: `pready` rises in cycle T+1+N.
- **Read data timing**:
  - The SRAM read is synchronous and launched at the SETUP edge.
  - `prdata` is registered and valid in the cycle `pready`=1.
  - `prdata` returns to 0 the cycle after.
- **Back-to-back transfers**: a new SETUP may arrive the cycle after ACCESS. No idle cycle is required, and every transfer takes exactly 2+N cycles.
- **Read-after-write**: a read of a word written by the immediately preceding transfer returns the new data. The write commits at the ACCESS edge, before the next SETUP read.
- **Output glitches**: `pready` and `pslverr` are registered outputs with no combinational path from `psel`.

## Configuration

- **Macro `DMEM_WAIT_STATES_EN`**:
  - **Defined**: the wait counter and the WAIT state are compiled in, and `WAIT_CYCLES` applies. An APB-protocol assertion block is also included, checking that `psel` is stable and that `paddr`, `pwrite` and `pwdata` are stable while `penable` is high.
  - **Undefined**: WAIT is removed, the wait count is forced to 0, every access is zero-wait, and `WAIT_CYCLES` is ignored.

## Structure

- **Shared package `typedefs`**: holds `apb_slv_state_e` and the `DMEM_WORD_BYTES`=4 constant.
- **Sub-module `sram_1rw_be`**:
  - Single-port word array with a synchronous read.
  - Four byte-write enables.
  - Write takes priority over read on the same index, with read-first semantics.
  - Parameterised by `DEPTH_WORDS`.
  - Contents are not reset.
- **`dmem_apb_slave` itself**: holds the FSM, address decode, wait counter and output registers.

## Test plan

- **Word write then read**:
  - Write `0xDEADBEEF` to `BASE+0x10` with `pstrb`=`4'hF`, then read the same address.
  - Expect `prdata`=`0xDEADBEEF` and `pslverr`=0.
  - Expect `pready` in the 2nd cycle of each transfer with zero wait, or the 4th cycle with `WAIT_CYCLES`=2.
- **Byte and half strobes**:
  - Preload `0x11223344`, then write `pwdata`=`0xAABBCCDD` with `pstrb`=`4'b0100`.
  - Read back; expect `0x11BB3344`.
  - Then write with `pstrb`=`4'b0011`; expect `0x11BBCCDD`.
- **Errors**:
  - Read `BASE+0x2`: expect `pslverr`=1 and `prdata`=0.
  - Write to `BASE+DEPTH_WORDS*4`: expect `pslverr`=1, and verify all memory words are unchanged.
- **Back-to-back traffic**: 50 random write/read pairs with no idle cycles. Expect a scoreboard match and exactly 2+N cycles per transfer.
- **Reset mid-write**:
  - Assert `rst` during WAIT of a write to `BASE+0x20`, whose prior value is `0x5`.
  - Expect `pready`=0 and state IDLE next cycle.
  - A subsequent read returns `0x5`.
- **Reset values**: hold `rst` for 3 cycles. Expect `pready`=0, `pslverr`=0 and `prdata`=0 throughout, and the first SETUP after release is served normally.
